// File: rtl/avs_frame_scheduler.sv
// avs_frame_scheduler
//   Front-end sequencer for the AVS detection DSP. It takes one
//   (vectorx, vectory, pressure) sample per accepted strobe. One shared
//   16x16 signed multiplier forms p*vx, p*vy and p*p over three cycles.
//   The products are accumulated over FRAME_LEN samples. At frame end
//   the sums are published with a one-cycle out_valid pulse.
//
// Ports
//   clock, reset       rising-edge clock, async active-low reset
//   sync_clr           synchronous abort of the current frame and sample
//   in_valid/in_ready  sample handshake; in_ready is high only in IDLE
//   vectorx/vectory    signed particle velocity, x and y
//   pressure           signed pressure
//   out_valid          one-cycle pulse; intens_x/intens_y/energy are new
//   intens_x/intens_y  sum of p*vx and p*vy over the frame
//   energy             sum of p*p over the frame
//   overrun            sticky: a sample was offered while in_ready=0
module avs_frame_scheduler #(
  parameter int FRAME_LEN = 256,
  parameter int ACC_W     = 40
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sync_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [15:0]      vectorx,
  input  logic signed [15:0]      vectory,
  input  logic signed [15:0]      pressure,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] intens_x,
  output logic signed [ACC_W-1:0] intens_y,
  output logic signed [ACC_W-1:0] energy,
  output logic                    overrun
);

  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic [2:0] {IDLE, MUL_X, MUL_Y, MUL_P, DUMP} state_t;

  typedef struct packed {
    logic [15:0] vx;
    logic [15:0] vy;
    logic [15:0] p;
  } sample_t;

  state_t                  state, nxt;
  sample_t                 smp;
  logic [CW-1:0]           cnt;
  logic signed [ACC_W-1:0] acc_x, acc_y, acc_e;
  logic signed [15:0]      opb;
  logic signed [31:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    accept;
  logic                    last_smp;

  assign accept   = in_valid & in_ready;
  assign last_smp = (cnt == CW'(FRAME_LEN - 1));

  // Single multiplier. Pressure is always one operand, and the state
  // picks the other. (-32768)^2 = 2^30 still fits a signed 32-bit product.
  always_comb begin
    opb = $signed(smp.p);
    case (state)
      MUL_X:   opb = $signed(smp.vx);
      MUL_Y:   opb = $signed(smp.vy);
      default: opb = $signed(smp.p);
    endcase
  end

  assign prod     = $signed(smp.p) * opb;
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};

  always_comb begin
    nxt = state;
    if (sync_clr) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (accept) nxt = MUL_X;
        MUL_X:   nxt = MUL_Y;
        MUL_Y:   nxt = MUL_P;
        MUL_P:   nxt = last_smp ? DUMP : IDLE;
        DUMP:    nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      smp       <= '0;
      cnt       <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      acc_e     <= '0;
      intens_x  <= '0;
      intens_y  <= '0;
      energy    <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= nxt;
      // Registered decode: ready whenever the next state is IDLE.
      in_ready  <= (nxt == IDLE);
      out_valid <= 1'b0;
      if (sync_clr) begin
        smp     <= '0;
        cnt     <= '0;
        acc_x   <= '0;
        acc_y   <= '0;
        acc_e   <= '0;
        overrun <= 1'b0;
      end else begin
        if (in_valid && !in_ready) overrun <= 1'b1;
        case (state)
          IDLE:  if (accept) smp <= '{vx: vectorx, vy: vectory, p: pressure};
          MUL_X: acc_x <= acc_x + prod_ext;
          MUL_Y: acc_y <= acc_y + prod_ext;
          MUL_P: begin
            acc_e <= acc_e + prod_ext;
            if (!last_smp) cnt <= cnt + 1'b1;
          end
          DUMP: begin
            intens_x  <= acc_x;
            intens_y  <= acc_y;
            energy    <= acc_e;
            acc_x     <= '0;
            acc_y     <= '0;
            acc_e     <= '0;
            cnt       <= '0;
            out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
